// File: rtl/gmii_speed_pkg.sv
// Shared speed encodings and FSM state types for the GMII/MII speed adapter.
package gmii_speed_pkg;

  localparam logic [1:0] SPD_1G   = 2'b10;
  localparam logic [1:0] SPD_100M = 2'b01;
  localparam logic [1:0] SPD_10M  = 2'b00;

  typedef enum logic {TX_LO, TX_HI} tx_state_t;
  typedef enum logic {RX_LO, RX_HI} rx_state_t;

  // 2'b11 is treated as 1G, so bit 1 alone selects byte mode.
  function automatic logic is_1g(input logic [1:0] spd);
    return spd[1];
  endfunction

endpackage

// File: rtl/gmii_speed_ce_gen.sv
// Nibble-strobe prescaler and speed-change detector for the speed adapter.
module gmii_speed_ce_gen
  import gmii_speed_pkg::*;
#(
  parameter int DIV_100M = 5,
  parameter int DIV_10M  = 50,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  output logic       nib_ce,
  output logic       spd_chg,
  output logic       mode_1g
);

  logic [1:0]       speed_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;
  logic             run;

  assign spd_chg = (speed != speed_q);
  assign mode_1g = is_1g(speed_q);
  assign div_m1  = (speed_q == SPD_100M) ? CNT_W'(DIV_100M - 1) : CNT_W'(DIV_10M - 1);

  // run keeps every strobe low until the first edge after reset release.
  assign nib_ce = run & ~spd_chg & (mode_1g | (cnt == div_m1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= SPD_1G;
      cnt     <= '0;
      run     <= 1'b0;
    end else begin
      run     <= 1'b1;
      speed_q <= speed;
      if (spd_chg || mode_1g || (cnt == div_m1)) cnt <= '0;
      else                                     cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gmii_mii_speed_adapter.sv
// Tri-speed byte<->nibble adapter between a byte-wide MAC and a GMII/MII pin stage.
module gmii_mii_speed_adapter
  import gmii_speed_pkg::*;
#(
  parameter int DIV_100M = 5,
  parameter int DIV_10M  = 50,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  output logic       mac_tx_ce,
  input  logic [7:0] mac_txd,
  input  logic       mac_tx_en,
  input  logic       mac_tx_er,
  output logic [7:0] phy_txd,
  output logic       phy_tx_en,
  output logic       phy_tx_er,
  output logic       phy_tx_ce,
  input  logic [7:0] phy_rxd,
  input  logic       phy_rx_dv,
  input  logic       phy_rx_er,
  input  logic       phy_rx_ce,
  output logic [7:0] mac_rxd,
  output logic       mac_rx_dv,
  output logic       mac_rx_er,
  output logic       mac_rx_ce,
  output logic       rx_align_err
);

  logic nib_ce, spd_chg, mode_1g;

  gmii_speed_ce_gen #(
    .DIV_100M(DIV_100M), .DIV_10M(DIV_10M), .CNT_W(CNT_W)
  ) u_ce_gen (
    .clk(clk), .rst_n(rst_n), .speed(speed),
    .nib_ce(nib_ce), .spd_chg(spd_chg), .mode_1g(mode_1g)
  );

  tx_state_t tx_state, tx_state_n;
  logic [7:0] hold, hold_n, txd_n;
  logic       txen_n, txer_n, txce_n;

  rx_state_t rx_state, rx_state_n;
  logic [3:0] lo_nib, lo_nib_n;
  logic       er_lo, er_lo_n, in_frame, in_frame_n;
  logic [7:0] rxd_n;
  logic       rxdv_n, rxer_n, rxce_n, align_n;

  assign mac_tx_ce = nib_ce & (mode_1g | (tx_state == TX_LO));

  always_comb begin
    tx_state_n = tx_state;
    hold_n     = hold;
    txd_n      = phy_txd;
    txen_n     = phy_tx_en;
    txer_n     = phy_tx_er;
    txce_n     = 1'b0;
    if (spd_chg) begin
      tx_state_n = TX_LO;
      txd_n      = '0;
      txen_n     = 1'b0;
      txer_n     = 1'b0;
    end else if (nib_ce) begin
      txce_n = 1'b1;
      if (mode_1g) begin
        tx_state_n = TX_LO;
        txd_n      = mac_txd;
        txen_n     = mac_tx_en;
        txer_n     = mac_tx_er;
      end else if (tx_state == TX_LO) begin
        hold_n     = mac_txd;
        txd_n      = {4'h0, mac_txd[3:0]};
        txen_n     = mac_tx_en;
        txer_n     = mac_tx_er;
        tx_state_n = TX_HI;
      end else begin
        txd_n      = {4'h0, hold[7:4]};
        tx_state_n = TX_LO;
      end
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    lo_nib_n   = lo_nib;
    er_lo_n    = er_lo;
    in_frame_n = in_frame;
    rxd_n      = mac_rxd;
    rxdv_n     = mac_rx_dv;
    rxer_n     = mac_rx_er;
    rxce_n     = 1'b0;
    align_n    = 1'b0;
    // A speed change takes priority over a coincident RX sample.
    if (spd_chg) begin
      rx_state_n = RX_LO;
      in_frame_n = 1'b0;
      rxdv_n     = 1'b0;
      rxer_n     = 1'b0;
    end else if (phy_rx_ce) begin
      if (mode_1g) begin
        rx_state_n = RX_LO;
        rxd_n      = phy_rxd;
        rxdv_n     = phy_rx_dv;
        rxer_n     = phy_rx_er;
        rxce_n     = 1'b1;
      end else if (phy_rx_dv) begin
        if (rx_state == RX_LO) begin
          lo_nib_n   = phy_rxd[3:0];
          er_lo_n    = phy_rx_er;
          rx_state_n = RX_HI;
        end else begin
          rxd_n      = {phy_rxd[3:0], lo_nib};
          rxdv_n     = 1'b1;
          rxer_n     = er_lo | phy_rx_er;
          rxce_n     = 1'b1;
          in_frame_n = 1'b1;
          rx_state_n = RX_LO;
        end
      end else if (in_frame || (rx_state == RX_HI)) begin
        // Frame end: one dv=0 beat, flagging a dangling low nibble.
        align_n    = (rx_state == RX_HI);
        rxdv_n     = 1'b0;
        rxer_n     = 1'b0;
        rxce_n     = 1'b1;
        in_frame_n = 1'b0;
        rx_state_n = RX_LO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state     <= TX_LO;
      hold         <= '0;
      phy_txd      <= '0;
      phy_tx_en    <= 1'b0;
      phy_tx_er    <= 1'b0;
      phy_tx_ce    <= 1'b0;
      rx_state     <= RX_LO;
      lo_nib       <= '0;
      er_lo        <= 1'b0;
      in_frame     <= 1'b0;
      mac_rxd      <= '0;
      mac_rx_dv    <= 1'b0;
      mac_rx_er    <= 1'b0;
      mac_rx_ce    <= 1'b0;
      rx_align_err <= 1'b0;
    end else begin
      tx_state     <= tx_state_n;
      hold         <= hold_n;
      phy_txd      <= txd_n;
      phy_tx_en    <= txen_n;
      phy_tx_er    <= txer_n;
      phy_tx_ce    <= txce_n;
      rx_state     <= rx_state_n;
      lo_nib       <= lo_nib_n;
      er_lo        <= er_lo_n;
      in_frame     <= in_frame_n;
      mac_rxd      <= rxd_n;
      mac_rx_dv    <= rxdv_n;
      mac_rx_er    <= rxer_n;
      mac_rx_ce    <= rxce_n;
      rx_align_err <= align_n;
    end
  end

endmodule

// File: tb/tb_gmii_mii_speed_adapter.sv
// Self-checking bench for gmii_mii_speed_adapter: TX pass-through/serialisation,
// RX reassembly with an expected-beat queue, speed change and async reset.
module tb_gmii_mii_speed_adapter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] speed;
  logic       mac_tx_ce;
  logic [7:0] mac_txd;
  logic       mac_tx_en, mac_tx_er;
  logic [7:0] phy_txd;
  logic       phy_tx_en, phy_tx_er, phy_tx_ce;
  logic [7:0] phy_rxd;
  logic       phy_rx_dv, phy_rx_er, phy_rx_ce;
  logic [7:0] mac_rxd;
  logic       mac_rx_dv, mac_rx_er, mac_rx_ce, rx_align_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // RX beats: {align, dv, er, data}; data is zero for dv=0 beats.
  logic [10:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [10:0] mon_act, mon_exp;

  always #4 clk = ~clk;

  gmii_mii_speed_adapter dut (
    .clk(clk), .rst_n(rst_n), .speed(speed),
    .mac_tx_ce(mac_tx_ce), .mac_txd(mac_txd), .mac_tx_en(mac_tx_en), .mac_tx_er(mac_tx_er),
    .phy_txd(phy_txd), .phy_tx_en(phy_tx_en), .phy_tx_er(phy_tx_er), .phy_tx_ce(phy_tx_ce),
    .phy_rxd(phy_rxd), .phy_rx_dv(phy_rx_dv), .phy_rx_er(phy_rx_er), .phy_rx_ce(phy_rx_ce),
    .mac_rxd(mac_rxd), .mac_rx_dv(mac_rx_dv), .mac_rx_er(mac_rx_er), .mac_rx_ce(mac_rx_ce),
    .rx_align_err(rx_align_err)
  );

  // RX scoreboard: every mac_rx_ce beat must match the head of exp_q.
  always @(negedge clk) begin
    if (mac_rx_ce) begin
      total_cnt++;
      mon_act = {rx_align_err, mac_rx_dv, mac_rx_er, mac_rx_dv ? mac_rxd : 8'h00};
      if (exp_q.size() == 0) begin
        $display("FAIL rx_unexpected: got beat %h, none expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) $display("FAIL rx_beat: got %h required %h", mon_act, mon_exp);
        else pass_cnt++;
      end
    end else if (rx_align_err) begin
      total_cnt++;
      $display("FAIL rx_align_stray: got 1 required 0 outside a beat");
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_sample(input logic [3:0] nib, input logic dv, input logic er, input int gap);
    phy_rxd   = {4'($urandom_range(0, 15)), nib};
    phy_rx_dv = dv;
    phy_rx_er = er;
    phy_rx_ce = 1'b1;
    tick();
    phy_rx_ce = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic check_drained(input string name);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s: %0d beats outstanding, required 0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({mac_tx_ce, phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce, mac_rxd, mac_rx_dv,
         mac_rx_er, mac_rx_ce, rx_align_err} !== 24'h0) begin
      $display("FAIL reset_outputs: got tx %h/%b%b%b%b rx %h/%b%b%b%b required all 0",
               phy_txd, mac_tx_ce, phy_tx_en, phy_tx_er, phy_tx_ce,
               mac_rxd, mac_rx_dv, mac_rx_er, mac_rx_ce, rx_align_err);
    end else pass_cnt++;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total_cnt++;
    if (phy_tx_ce !== 1'b1 || mac_tx_ce !== 1'b1)
      $display("FAIL reset_release_1g_ce: got phy_tx_ce=%b mac_tx_ce=%b required 1/1", phy_tx_ce, mac_tx_ce);
    else pass_cnt++;
  endtask

  task automatic test_tx_1g();
    logic [7:0] bytes [3];
    logic [7:0] e;
    bytes[0] = 8'h55; bytes[1] = 8'hD5; bytes[2] = 8'hA1;
    tick();
    mac_txd = bytes[0]; mac_tx_en = 1'b1; tx_q.push_back(bytes[0]);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) begin mac_txd = bytes[i]; tx_q.push_back(bytes[i]); end
      else begin mac_txd = 8'h00; mac_tx_en = 1'b0; end
      @(negedge clk);
      e = tx_q.pop_front();
      total_cnt++;
      if ({phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce, mac_tx_ce} !== {e, 4'b1011})
        $display("FAIL tx_1g_byte%0d: got %h en%b er%b ce%b mce%b required %h 1 0 1 1",
                 i - 1, phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce, mac_tx_ce, e);
      else pass_cnt++;
    end
    tick();
    @(negedge clk);
    total_cnt++;
    if (phy_tx_en !== 1'b0) $display("FAIL tx_1g_en_drop: got %b required 0", phy_tx_en);
    else pass_cnt++;
  endtask

  task automatic test_tx_100m();
    logic found;
    logic [7:0] e;
    found = 1'b0;
    tick();
    speed = 2'b01; mac_txd = 8'hA5; mac_tx_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mac_tx_ce) begin found = 1'b1; break; end
    end
    total_cnt++;
    if (!found) $display("FAIL tx_100m_ce_timeout: got no mac_tx_ce in 30 cycles, required one");
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e = (i < 5) ? 8'h05 : 8'h0A;
      total_cnt++;
      if (phy_txd !== e || phy_tx_en !== 1'b1)
        $display("FAIL tx_100m_nib%0d: got %h en%b required %h en1", i, phy_txd, phy_tx_en, e);
      else pass_cnt++;
      total_cnt++;
      if (phy_tx_ce !== (i == 0 || i == 5) || mac_tx_ce !== (i == 9))
        $display("FAIL tx_100m_strobe%0d: got phy_tx_ce=%b mac_tx_ce=%b required %b %b",
                 i, phy_tx_ce, mac_tx_ce, (i == 0 || i == 5), (i == 9));
      else pass_cnt++;
    end
    tick();
    mac_tx_en = 1'b0; mac_txd = 8'h00;
  endtask

  task automatic test_rx_10m();
    tick();
    speed = 2'b00;
    repeat (4) tick();
    rx_sample(4'h5, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h55});
    rx_sample(4'h5, 1'b1, 1'b0, 50);
    rx_sample(4'hD, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h5D});
    rx_sample(4'h5, 1'b1, 1'b0, 50);
    rx_sample(4'h1, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'hA1});
    rx_sample(4'hA, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});
    rx_sample(4'h0, 1'b0, 1'b0, 50);
    rx_sample(4'h0, 1'b0, 1'b0, 50);
    check_drained("rx_10m_drain");
  endtask

  task automatic test_rx_odd();
    rx_sample(4'h2, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h72});
    rx_sample(4'h7, 1'b1, 1'b0, 50);
    rx_sample(4'h9, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h00});
    rx_sample(4'h0, 1'b0, 1'b0, 50);
    check_drained("rx_odd_drain");
  endtask

  task automatic test_rx_er_merge();
    rx_sample(4'h1, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'h21});
    rx_sample(4'h2, 1'b1, 1'b1, 50);
    rx_sample(4'h3, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h43});
    rx_sample(4'h4, 1'b1, 1'b0, 50);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});
    rx_sample(4'h0, 1'b0, 1'b0, 50);
    check_drained("rx_er_drain");
  endtask

  task automatic test_rx_speed_collision();
    rx_sample(4'h6, 1'b1, 1'b0, 20);
    // Completing nibble arrives in the same cycle as a speed change: dropped.
    phy_rxd = 8'h07; phy_rx_dv = 1'b1; phy_rx_er = 1'b0; phy_rx_ce = 1'b1;
    speed = 2'b01;
    tick();
    phy_rx_ce = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    total_cnt++;
    if (mac_rx_dv !== 1'b0) $display("FAIL rx_spdchg_drop: got dv=%b required 0", mac_rx_dv);
    else pass_cnt++;
    tick();
    rx_sample(4'h8, 1'b1, 1'b0, 10);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h98});
    rx_sample(4'h9, 1'b1, 1'b0, 10);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});
    rx_sample(4'h0, 1'b0, 1'b0, 10);
    check_drained("rx_spdchg_drain");
  endtask

  task automatic test_rx_random();
    logic [3:0] lo, hi;
    logic       el, eh;
    for (int b = 0; b < 4; b++) begin
      lo = 4'($urandom_range(0, 15)); hi = 4'($urandom_range(0, 15));
      el = 1'($urandom_range(0, 1));  eh = 1'($urandom_range(0, 1));
      rx_sample(lo, 1'b1, el, 10);
      exp_q.push_back({1'b0, 1'b1, el | eh, hi, lo});
      rx_sample(hi, 1'b1, eh, 10);
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});
    rx_sample(4'h0, 1'b0, 1'b0, 10);
    check_drained("rx_random_drain");
  endtask

  task automatic test_speed_change();
    logic found;
    found = 1'b0;
    tick();
    speed = 2'b01; mac_txd = 8'hA5; mac_tx_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mac_tx_ce) begin found = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    total_cnt++;
    if (!found || phy_tx_en !== 1'b1)
      $display("FAIL spdchg_midframe: got found=%b en=%b required 1/1", found, phy_tx_en);
    else pass_cnt++;
    tick();
    speed = 2'b10; mac_txd = 8'h77;
    @(negedge clk);
    total_cnt++;
    if (mac_tx_ce !== 1'b0) $display("FAIL spdchg_ce_gate: got mac_tx_ce=%b required 0", mac_tx_ce);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce} !== 11'h0)
      $display("FAIL spdchg_clear: got %h en%b er%b ce%b required all 0",
               phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce, mac_tx_ce} !== {8'h77, 4'b1011})
      $display("FAIL spdchg_resume: got %h en%b er%b ce%b mce%b required 77 1 0 1 1",
               phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce, mac_tx_ce);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    mac_txd = 8'h33; mac_tx_en = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mac_tx_ce, phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce, mac_rxd, mac_rx_dv,
         mac_rx_er, mac_rx_ce, rx_align_err} !== 24'h0)
      $display("FAIL reset_async_clear: got tx %h en%b ce%b mce%b rx %h dv%b required all 0",
               phy_txd, phy_tx_en, phy_tx_ce, mac_tx_ce, mac_rxd, mac_rx_dv);
    else pass_cnt++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total_cnt++;
    if (phy_txd !== 8'h33 || phy_tx_en !== 1'b1)
      $display("FAIL reset_resume_1g: got %h en%b required 33 en1", phy_txd, phy_tx_en);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; speed = 2'b10;
    mac_txd = 8'h00; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
    phy_rxd = 8'h00; phy_rx_dv = 1'b0; phy_rx_er = 1'b0; phy_rx_ce = 1'b0;
    test_reset();
    test_tx_1g();
    test_tx_100m();
    test_rx_10m();
    test_rx_odd();
    test_rx_er_merge();
    test_rx_speed_collision();
    test_rx_random();
    test_speed_change();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
